fetch_prefetch_unit: RTL

//  Next-generation IF stage: PC generator plus DEPTH-entry prefetch queue in front of a

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_prefetch_checker.sv | 21 ++
 rtl/fetch_prefetch_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and PC helpers for the instruction-fetch / prefetch slice.
package fetch_pkg;

  localparam int unsigned FETCH_AW    = 32;
  localparam int unsigned FETCH_DW    = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  // Word-align a fetch address; the two byte-offset bits are never fetched.
  function automatic logic [FETCH_AW-1:0] align_pc(input logic [FETCH_AW-1:0] addr);
    return addr & ~FETCH_AW'(3);
  endfunction

  function automatic logic [FETCH_AW-1:0] incr_pc(input logic [FETCH_AW-1:0] addr);
    return addr + FETCH_AW'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through queue of fetched {pc, instr} entries.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t   mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [PW:0]    count_r;
  logic [PW:0]    count_next_s;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign empty     = (count_r == (PW+1)'(0));
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + (PW+1)'(1);
      2'b01:   count_next_s = count_r - (PW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage and pointers; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/fetch_prefetch_checker.sv
// Protocol and credit assertions for the fetch unit.
module fetch_prefetch_checker #(
  parameter int unsigned OW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          imem_rvalid,
  input logic [OW-1:0] outstanding,
  input logic          fifo_push,
  input logic          fifo_full
);

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
  ) else $error("imem_rvalid with no outstanding request");

  a_no_queue_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) fifo_push |-> !fifo_full
  ) else $error("prefetch queue push while full");

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF stage: PC generator, credit-limited imem request issue and prefetch queue with redirect flush.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned             ADDRESS_WIDTH   = FETCH_AW,
  parameter int unsigned             DATA_WIDTH      = FETCH_DW,
  parameter int unsigned             DEPTH           = 4,
  parameter int unsigned             MAX_OUTSTANDING = 2,
  parameter logic [FETCH_AW-1:0]     RESET_PC        = {FETCH_AW{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]  redirect_pc,
  output logic                      imem_req,
  output logic [ADDRESS_WIDTH-1:0]  imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [DATA_WIDTH-1:0]     imem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_instr,
  output logic [ADDRESS_WIDTH-1:0]  out_pc,
  output logic [ADDRESS_WIDTH-1:0]  out_pcplus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  state_e                  state_r;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_r;
  logic [ADDRESS_WIDTH-1:0] ret_pc_r;
  logic [OW-1:0]           outst_r;
  logic [OW-1:0]           outst_next_s;
  logic [OW-1:0]           discard_r;

  logic                    req_s;
  logic                    gnt_fire_s;
  logic                    push_s;
  logic                    pop_s;
  logic [CW-1:0]           count_s;
  logic                    empty_s;
  logic                    full_s;
  logic [SW-1:0]           credit_sum_s;
  fetch_entry_t            push_entry_s;
  fetch_entry_t            head_s;

  // A request only goes out if its response is guaranteed a queue slot.
  assign credit_sum_s = SW'(count_s) + SW'(outst_r);
  assign req_s        = (state_r == S_RUN) & ~redirect_valid
                      & (outst_r < OW'(MAX_OUTSTANDING))
                      & (credit_sum_s < SW'(DEPTH));
  assign gnt_fire_s   = req_s & imem_gnt;

  assign push_s             = imem_rvalid & ~redirect_valid & (discard_r == '0);
  assign push_entry_s.pc    = ret_pc_r;
  assign push_entry_s.instr = imem_rdata;
  assign pop_s              = ~empty_s & out_ready;

  assign imem_req    = req_s;
  assign imem_addr   = fetch_pc_r;
  assign out_valid   = ~empty_s;
  assign out_instr   = head_s.instr;
  assign out_pc      = head_s.pc;
  assign out_pcplus4 = incr_pc(head_s.pc);

  // Granted-but-unreturned count after this cycle's grant and return.
  always_comb begin
    outst_next_s = outst_r;
    if (gnt_fire_s && !imem_rvalid) begin
      outst_next_s = outst_r + OW'(1);
    end else if (!gnt_fire_s && imem_rvalid) begin
      outst_next_s = outst_r - OW'(1);
    end else begin
      outst_next_s = outst_r;
    end
  end

  // Boot/run FSM with fetch PC, return PC and stale-response bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_BOOT;
      fetch_pc_r <= RESET_PC;
      ret_pc_r   <= RESET_PC;
      outst_r    <= '0;
      discard_r  <= '0;
    end else begin
      case (state_r)
        S_BOOT: begin
          state_r <= S_RUN;
        end
        S_RUN: begin
          outst_r <= outst_next_s;
          if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path.
            fetch_pc_r <= align_pc(redirect_pc);
            ret_pc_r   <= align_pc(redirect_pc);
            discard_r  <= outst_next_s;
          end else begin
            if (gnt_fire_s) fetch_pc_r <= incr_pc(fetch_pc_r);
            if (imem_rvalid) begin
              if (discard_r != '0) discard_r <= discard_r - OW'(1);
              else                 ret_pc_r  <= incr_pc(ret_pc_r);
            end
          end
        end
        default: begin
          state_r <= S_BOOT;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  fetch_prefetch_checker #(
    .OW (OW)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .outstanding (outst_r),
    .fifo_push   (push_s),
    .fifo_full   (full_s)
  );

endmodule
